ternary_serializer: RTL and testbench
=====================================

// Module: ternary_serializer
// PURPOSE
//   Transmit side of the two-wire trit link consumed by the ternary gate library
//   (ternary_max / ternary_consensus operand format).
//   Accepts one unsigned binary word per valid/ready handshake and converts it to
//   base 3 by repeated divide-by-3. Emits NTRITS trits, LSB trit first, one per
//   out handshake, on the (t0,t1) pair.
//   Trit encoding: 0 -> t0=0,t1=0 | 1 -> t0=1,t1=0 | 2 -> t0=0,t1=1.
//   Code t0=1,t1=1 is never driven.
// PARAMETERS
//   WIDTH   8  bit width of in_data (>=2)
//   NTRITS  6  trits emitted per word (>=1); 3**6=729 covers WIDTH=8 without overflow
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      in_data holds a word to send
//   in_ready   out  1      block can accept a word this cycle
//   in_data    in   WIDTH  unsigned binary word
//   out_valid  out  1      out_t0/out_t1 hold a valid trit
//   out_ready  in   1      sink takes the trit this cycle
//   out_t0     out  1      trit low wire (value 1)
//   out_t1     out  1      trit high wire (value 2)
//   out_last   out  1      current trit is trit NTRITS-1 of the word
//   out_ovf    out  1      valid with out_last: word did not fit in NTRITS trits
// BEHAVIOUR
//   - Reset (sync, clk edge with reset=1):
//     state=IDLE, out_valid=0, out_t0=out_t1=0, out_last=0, out_ovf=0,
//     rem=0, cnt=0. in_ready=1 from the first cycle after reset is released.
//     Reset mid-word abandons the word; no further trits of it are emitted.
//   - FSM IDLE:
//     in_ready=1, out_valid=0. On in_valid&in_ready:
//     trit reg <= in_data%3, rem <= in_data/3, cnt <= 0, go SEND.
//   - FSM SEND:
//     in_ready=0, out_valid=1; trit reg drives out_t0/out_t1.
//     out_last=(cnt==NTRITS-1). out_ovf=out_last&(rem!=0), else 0.
//   - On out_valid&out_ready, not last: trit reg <= rem%3, rem <= rem/3, cnt <= cnt+1.
//   - On out_valid&out_ready, last: go IDLE; out_valid, out_last and out_ovf drop next cycle.
//   - Stall (out_valid & !out_ready): out_t0, out_t1, out_last, out_ovf, rem and cnt
//     are held stable.
//   - Latency: first trit valid 1 cycle after the input handshake.
//     Minimum NTRITS+1 cycles per word (one IDLE cycle between words).
//   - All outputs are registered or decoded from state only; no combinational path
//     from in_* or out_ready to any output.
//   - rem is WIDTH bits and cnt is clog2(NTRITS+1) bits; no wrap within a word.
//   - in_valid while busy is ignored. The source holds the word until in_ready.
//   - NTRITS=1: a single trit carrying out_last=1; out_ovf=(in_data>=3).
// TESTING
//   1. in_data=0, out_ready=1 -> 6 trits 00; out_last on the 6th only; out_ovf=0.
//   2. in_data=5 -> trits 2,1,0,0,0,0 (t1t0 = 10,01,00,00,00,00); out_ovf=0.
//   3. in_data=255 -> trits 0,1,1,0,0,1; out_ovf=0; t0&t1 never both 1.
//   4. in_data=200, out_ready random 50% -> outputs stable on every stall cycle;
//      sequence 2,0,1,1,2,0; exactly 6 handshakes.
//   5. NTRITS=4, in_data=100 -> trits 1,0,2,0; out_ovf=1 with out_last.
//   6. reset after 2nd trit of in_data=255 -> next cycle out_valid=0, in_ready=1;
//      then in_data=5 -> stream restarts at trit 2, with no residue from the old word.

Source files
------------

// File: rtl/ternary_serializer.sv
// Binary-to-ternary serializer: one WIDTH-bit word in, NTRITS trits out (LSB trit first)
// on the two-wire (t0,t1) link with valid/ready on both sides.
module ternary_serializer #(
  parameter int WIDTH  = 8,
  parameter int NTRITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_t0,
  output logic             out_t1,
  output logic             out_last,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(NTRITS + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;

  function automatic logic [1:0] mod3(input logic [WIDTH-1:0] x);
    return 2'(x % WIDTH'(3));
  endfunction

  function automatic logic [WIDTH-1:0] div3(input logic [WIDTH-1:0] x);
    return x / WIDTH'(3);
  endfunction

  // Returns {t1,t0} for a trit value 0..2; 2'b11 is never produced.
  function automatic logic [1:0] enc(input logic [1:0] v);
    return {v == 2'd2, v == 2'd1};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SEND);

  // out_last/out_ovf are registered one step ahead: they describe the trit being loaded,
  // so "next cnt == NTRITS-1" is evaluated against the current cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      out_t0   <= 1'b0;
      out_t1   <= 1'b0;
      out_last <= 1'b0;
      out_ovf  <= 1'b0;
      rem      <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            {out_t1, out_t0} <= enc(mod3(in_data));
            rem              <= div3(in_data);
            cnt              <= '0;
            out_last         <= (NTRITS == 1);
            out_ovf          <= (NTRITS == 1) && (div3(in_data) != '0);
            state            <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state    <= IDLE;
              out_t0   <= 1'b0;
              out_t1   <= 1'b0;
              out_last <= 1'b0;
              out_ovf  <= 1'b0;
            end else begin
              {out_t1, out_t0} <= enc(mod3(rem));
              rem              <= div3(rem);
              cnt              <= cnt + CNT_W'(1);
              out_last         <= (cnt == CNT_W'(NTRITS - 2));
              out_ovf          <= (cnt == CNT_W'(NTRITS - 2)) && (div3(rem) != '0);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_serializer.sv
// Directed bench for ternary_serializer: a 6-trit instance and a 4-trit instance.
module tb_ternary_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid0, in_ready0, out_valid0, out_ready0;
  logic       out_t0_0, out_t1_0, out_last0, out_ovf0;
  logic [7:0] in_data0;
  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic       out_t0_1, out_t1_1, out_last1, out_ovf1;
  logic [7:0] in_data1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ternary_serializer #(.WIDTH(8), .NTRITS(6)) dut6 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_t0(out_t0_0), .out_t1(out_t1_0), .out_last(out_last0), .out_ovf(out_ovf0)
  );

  ternary_serializer #(.WIDTH(8), .NTRITS(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_t0(out_t0_1), .out_t1(out_t1_1), .out_last(out_last1), .out_ovf(out_ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Sends word d into dut6 (sel=0) or dut4 (sel=1) and checks n trits against exp
  // ({trit n-1, ..., trit 0}, 2 bits each). stop_after<n abandons after that many handshakes.
  task automatic run_word(input bit sel, input int n, input logic [7:0] d,
                          input logic [11:0] expt, input bit exp_ovf, input bit rnd,
                          input bit busy_noise, input int stop_after);
    int k = 0;
    int cyc = 0;
    logic [1:0] v;
    logic rdy;
    check($sformatf("in_ready_idle_%0d", d), sel ? in_ready1 : in_ready0, 1);
    if (sel) begin in_valid1 = 1'b1; in_data1 = d; end
    else     begin in_valid0 = 1'b1; in_data0 = d; end
    @(posedge clk); @(negedge clk);
    if (busy_noise) begin
      if (sel) in_data1 = 8'hAA; else in_data0 = 8'hAA;
    end else begin
      if (sel) in_valid1 = 1'b0; else in_valid0 = 1'b0;
    end
    while (k < n && k < stop_after && cyc < 200) begin
      v = expt[2*k +: 2];
      check($sformatf("valid_%0d_t%0d", d, k), sel ? out_valid1 : out_valid0, 1);
      check($sformatf("busy_%0d_t%0d", d, k), sel ? in_ready1 : in_ready0, 0);
      check($sformatf("t0_%0d_t%0d", d, k), sel ? out_t0_1 : out_t0_0, (v == 2'd1));
      check($sformatf("t1_%0d_t%0d", d, k), sel ? out_t1_1 : out_t1_0, (v == 2'd2));
      check($sformatf("last_%0d_t%0d", d, k), sel ? out_last1 : out_last0, (k == n - 1));
      check($sformatf("ovf_%0d_t%0d", d, k), sel ? out_ovf1 : out_ovf0,
            (exp_ovf && k == n - 1));
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel) out_ready1 = rdy; else out_ready0 = rdy;
      @(posedge clk);
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    if (sel) begin in_valid1 = 1'b0; out_ready1 = 1'b0; end
    else     begin in_valid0 = 1'b0; out_ready0 = 1'b0; end
    check($sformatf("handshakes_%0d", d), k, (stop_after < n) ? stop_after : n);
    if (stop_after >= n) begin
      check($sformatf("valid_drop_%0d", d), sel ? out_valid1 : out_valid0, 0);
      check($sformatf("last_drop_%0d", d), sel ? out_last1 : out_last0, 0);
      check($sformatf("ovf_drop_%0d", d), sel ? out_ovf1 : out_ovf0, 0);
      check($sformatf("ready_back_%0d", d), sel ? in_ready1 : in_ready0, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid0, 0);
    check("rst_t0", out_t0_0, 0);
    check("rst_t1", out_t1_0, 0);
    check("rst_last", out_last0, 0);
    check("rst_ovf", out_ovf0, 0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_in_ready", in_ready0, 1);
    check("rst_valid4", out_valid1, 0);

    // 0 -> all zero trits
    run_word(0, 6, 8'd0,   {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1'b0, 1'b0, 1'b0, 99);
    // 5 -> 2,1,0,0,0,0
    run_word(0, 6, 8'd5,   {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2}, 1'b0, 1'b0, 1'b0, 99);
    // 255 -> 0,1,1,0,0,1
    run_word(0, 6, 8'd255, {2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0}, 1'b0, 1'b0, 1'b0, 99);
    // 200 -> 2,0,1,1,2,0 with random back-pressure and in_valid asserted while busy
    run_word(0, 6, 8'd200, {2'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd2}, 1'b0, 1'b1, 1'b1, 99);
    // 242 = 22222 (base 3): largest 5-trit value, sixth trit 0
    run_word(0, 6, 8'd242, {2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, 1'b0, 1'b1, 1'b0, 99);
    // 4-trit instance: 100 -> 1,0,2,0 remainder 1 -> overflow
    run_word(1, 4, 8'd100, {4'd0, 2'd0, 2'd2, 2'd0, 2'd1}, 1'b1, 1'b0, 1'b0, 99);
    // 4-trit instance: 80 = 2222 (base 3) fits exactly, no overflow
    run_word(1, 4, 8'd80,  {4'd0, 2'd2, 2'd2, 2'd2, 2'd2}, 1'b0, 1'b1, 1'b0, 99);

    // reset after the 2nd trit of 255, then 5 must start cleanly
    run_word(0, 6, 8'd255, {2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0}, 1'b0, 1'b0, 1'b0, 2);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("midrst_valid", out_valid0, 0);
    check("midrst_in_ready", in_ready0, 1);
    run_word(0, 6, 8'd5,   {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2}, 1'b0, 1'b0, 1'b0, 99);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
